// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the two requesters, the shared combinational ALU and
// the alu_share_arbiter sequencer.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
);
    logic             req0;
    logic [OPW-1:0]   op0;
    logic [WIDTH-1:0] A0;
    logic [WIDTH-1:0] B0;
    logic             req1;
    logic [OPW-1:0]   op1;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] B1;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic [WIDTH-1:0] alu_result;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport slave (
        input  req0, op0, A0, B0, req1, op1, A1, B1, alu_result,
        output alu_op, alu_A, alu_B, gnt0, gnt1, done0, done1, result, busy
    );

    modport master (
        output req0, op0, A0, B0, req1, op1, A1, B1, alu_result,
        input  alu_op, alu_A, alu_B, gnt0, gnt1, done0, done1, result, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer time-sharing one combinational ALU between two
// requesters: IDLE (arbitrate + latch) -> ISSUE (gnt) -> CAPTURE (done).
module alu_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_ptr;
    logic             r_sel;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             w_any;
    logic             w_win;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Winner: pointer channel on contention, otherwise the lone requester.
    always_comb begin
        w_any  = bus.req0 | bus.req1;
        w_win  = (bus.req0 & bus.req1) ? r_ptr : bus.req1;
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.gnt0   = (r_state == S_ISSUE)   & ~r_sel;
        bus.gnt1   = (r_state == S_ISSUE)   &  r_sel;
        bus.done0  = (r_state == S_CAPTURE) & ~r_sel;
        bus.done1  = (r_state == S_CAPTURE) &  r_sel;
        bus.busy   = (r_state != S_IDLE);
        bus.alu_op = r_op;
        bus.alu_A  = r_a;
        bus.alu_B  = r_b;
        bus.result = r_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= 1'b0;
            r_sel    <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_sel <= w_win;
                r_ptr <= ~w_win;
                r_op  <= w_win ? bus.op1 : bus.op0;
                r_a   <= w_win ? bus.A1  : bus.A0;
                r_b   <= w_win ? bus.B1  : bus.B0;
            end
            if (r_state == S_ISSUE)
                r_result <= bus.alu_result;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; the shared ALU is modelled as NAND.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(4), .OPW(3)) bus ();
    assign bus.alu_result = ~(bus.alu_A & bus.alu_B);

    alu_share_arbiter #(.WIDTH(4), .OPW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic test_reset();
        logic [3:0] hs;
        rst = 1'b1;
        bus.req0 = 0; bus.req1 = 0;
        bus.op0 = 3'b101; bus.A0 = 4'b1010; bus.B0 = 4'b1011;
        bus.op1 = 3'b010; bus.A1 = 4'b0000; bus.B1 = 4'b1111;
        @(negedge clk); @(negedge clk);
        hs = {bus.gnt0, bus.gnt1, bus.done0, bus.done1};
        n_checks++;
        if (hs !== 4'b0000 || bus.busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_ctrl: got gnt/done=%b busy=%b, expected 0000 0", hs, bus.busy);
        end
        n_checks++;
        if ({bus.result, bus.alu_A, bus.alu_B, bus.alu_op} !== 15'd0) begin
            n_errors++; $display("FAIL reset_data: got result=%b A=%b B=%b op=%b, expected all 0",
                                 bus.result, bus.alu_A, bus.alu_B, bus.alu_op);
        end
    endtask

    task automatic test_single_ch0();
        bus.req0 = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b10001) begin
            n_errors++; $display("FAIL ch0_gnt: got gnt0,gnt1,done0,done1,busy=%b, expected 10001",
                                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy});
        end
        n_checks++;
        if ({bus.alu_op, bus.alu_A, bus.alu_B} !== {3'b101, 4'b1010, 4'b1011}) begin
            n_errors++; $display("FAIL ch0_alu_in: got op=%b A=%b B=%b, expected 101 1010 1011",
                                 bus.alu_op, bus.alu_A, bus.alu_B);
        end
        bus.req0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b00101 || bus.result !== 4'b0101) begin
            n_errors++; $display("FAIL ch0_done: got flags=%b result=%b, expected 00101 0101",
                                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, bus.result);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b00000 || bus.result !== 4'b0101) begin
            n_errors++; $display("FAIL ch0_idle_hold: got flags=%b result=%b, expected 00000 0101",
                                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, bus.result);
        end
    endtask

    task automatic test_single_ch1_and_pointer();
        bus.req1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 4'b0100 ||
            {bus.alu_op, bus.alu_A, bus.alu_B} !== {3'b010, 4'b0000, 4'b1111}) begin
            n_errors++; $display("FAIL ch1_gnt: got flags=%b op=%b A=%b B=%b, expected 0100 010 0000 1111",
                                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, bus.alu_op, bus.alu_A, bus.alu_B);
        end
        bus.req1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 4'b0001 || bus.result !== 4'b1111) begin
            n_errors++; $display("FAIL ch1_done: got flags=%b result=%b, expected 0001 1111",
                                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, bus.result);
        end
        @(negedge clk);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            n_errors++; $display("FAIL ptr_after_ch1: got gnt0,gnt1=%b, expected 10", {bus.gnt0, bus.gnt1});
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.done0 !== 1'b1 || bus.result !== 4'b0101) begin
            n_errors++; $display("FAIL ptr_done0: got done0=%b result=%b, expected 1 0101", bus.done0, bus.result);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_hs;
        logic [3:0] got_hs;
        rst = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            // Cycle k: phase 0 = ISSUE, 1 = CAPTURE, 2 = IDLE; ops alternate ch0, ch1, ch0.
            case (k)
                1, 7:    exp_hs = 4'b1000;
                2, 8:    exp_hs = 4'b0010;
                4:       exp_hs = 4'b0100;
                5:       exp_hs = 4'b0001;
                default: exp_hs = 4'b0000;
            endcase
            got_hs = {bus.gnt0, bus.gnt1, bus.done0, bus.done1};
            n_checks++;
            if (got_hs !== exp_hs) begin
                n_errors++; $display("FAIL b2b_hs[%0d]: got gnt0,gnt1,done0,done1=%b, expected %b", k, got_hs, exp_hs);
            end
            if (k == 2 || k == 5 || k == 8) begin
                n_checks++;
                if (bus.result !== ((k == 5) ? 4'b1111 : 4'b0101)) begin
                    n_errors++; $display("FAIL b2b_result[%0d]: got %b, expected %b", k, bus.result,
                                         (k == 5) ? 4'b1111 : 4'b0101);
                end
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_operand_latch();
        bus.A0 = 4'b1010; bus.B0 = 4'b1011;
        bus.req0 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.gnt0 !== 1'b1) begin
            n_errors++; $display("FAIL latch_gnt0: got %b, expected 1", bus.gnt0);
        end
        bus.A0 = 4'b1111; bus.req0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.done0 !== 1'b1 || bus.result !== 4'b0101 || bus.alu_A !== 4'b1010) begin
            n_errors++; $display("FAIL latch_result: got done0=%b result=%b alu_A=%b, expected 1 0101 1010",
                                 bus.done0, bus.result, bus.alu_A);
        end
        @(negedge clk);
        bus.A0 = 4'b1010;
    endtask

    task automatic test_reset_mid_op();
        bus.req1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.gnt1 !== 1'b1) begin
            n_errors++; $display("FAIL midrst_gnt1: got %b, expected 1", bus.gnt1);
        end
        rst = 1'b1; bus.req1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.done0, bus.done1, bus.busy} !== 3'b000 || bus.result !== 4'b0000) begin
            n_errors++; $display("FAIL midrst_drop: got done0,done1,busy=%b result=%b, expected 000 0000",
                                 {bus.done0, bus.done1, bus.busy}, bus.result);
        end
        rst = 1'b0; bus.req0 = 1'b1; bus.req1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            n_errors++; $display("FAIL midrst_ptr: got gnt0,gnt1=%b, expected 10", {bus.gnt0, bus.gnt1});
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.done0, bus.done1} !== 2'b10 || bus.result !== 4'b0101) begin
            n_errors++; $display("FAIL midrst_done: got done0,done1=%b result=%b, expected 10 0101",
                                 {bus.done0, bus.done1}, bus.result);
        end
        @(negedge clk);
    endtask

    task automatic test_req_while_busy();
        bus.req1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.gnt1 !== 1'b1) begin
            n_errors++; $display("FAIL busy_gnt1: got %b, expected 1", bus.gnt1);
        end
        bus.req1 = 1'b0; bus.req0 = 1'b1;
        @(negedge clk);
        bus.req0 = 1'b0;
        n_checks++;
        if (bus.done1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
            n_errors++; $display("FAIL busy_done1: got done1=%b gnt0=%b, expected 1 0", bus.done1, bus.gnt0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.gnt0 !== 1'b0 || bus.busy !== 1'b0) begin
                n_errors++; $display("FAIL busy_ignored[%0d]: got gnt0=%b busy=%b, expected 0 0", k, bus.gnt0, bus.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_ch0();
        test_single_ch1_and_pointer();
        test_back_to_back();
        test_operand_latch();
        test_reset_mid_op();
        test_req_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
